// File: rtl/pcie_mmio_responder_pkg.sv
// Shared TLP definitions: header layouts, state encoding and completion helpers
// used by the MMIO completer. Each header DW is MSB-first, so DW0[31] is r0.
package pcie_mmio_responder_pkg;

  typedef enum logic [1:0] {
    MRd_3DW_NO_DATA = 2'b00,
    MRd_4DW_NO_DATA = 2'b01,
    MWr_3DW_DATA    = 2'b10,
    MWr_4DW_DATA    = 2'b11
  } tlp_fmt_e;

  typedef enum logic [4:0] {
    MEMORY_RW = 5'b00000,
    IO_RW     = 5'b00010,
    CFG0      = 5'b00100,
    CFG1      = 5'b00101,
    CPL       = 5'b01010
  } tlp_type_e;

  typedef struct packed {
    logic       r0;
    tlp_fmt_e   fmt;
    tlp_type_e  typ;
    logic       r1;
    logic [2:0] tc;
    logic [3:0] r2;
    logic       digest;
    logic       poison;
    logic [1:0] attr;
    logic [1:0] at;
    logic [9:0] length;
  } tlp_dw0_t;

  typedef struct packed {
    logic [15:0] reqid;
    logic [7:0]  tag;
    logic [3:0]  lastbe;
    logic [3:0]  firstbe;
  } req_dw1_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [1:0]  r;
  } addr_dw2_t;

  typedef struct packed {
    logic [15:0] cplid;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] bytecount;
  } cpl_dw1_t;

  typedef struct packed {
    logic [15:0] reqid;
    logic [7:0]  tag;
    logic        r;
    logic [6:0]  loweraddr;
  } cpl_dw2_t;

  typedef struct packed {
    tlp_dw0_t  dw0;
    req_dw1_t  dw1;
    addr_dw2_t dw2;
  } req_fields_t;

  typedef struct packed {
    tlp_dw0_t dw0;
    cpl_dw1_t dw1;
    cpl_dw2_t dw2;
  } cpl_fields_t;

  typedef union packed {
    req_fields_t f;
    logic [95:0] raw;
  } tlp_3dw_header;

  typedef union packed {
    cpl_fields_t f;
    logic [95:0] raw;
  } tlp_cpl_header;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_DROP,
    ST_WRITE,
    ST_READ,
    ST_RWAIT,
    ST_CPL0,
    ST_CPL1
  } rsp_state_e;

  // A CplD carries data, so it reuses the 3DW-with-data format code.
  localparam tlp_fmt_e  CPLD_FMT  = MWr_3DW_DATA;
  localparam tlp_type_e CPLD_TYPE = CPL;

  // Byte count of a 1-DW completion: span from lowest to highest enabled byte.
  function automatic logic [11:0] cpl_bytecount(input logic [3:0] firstbe);
    logic [2:0] hi;
    logic [2:0] lo;
    hi = 3'd0;
    lo = 3'd0;
    for (int i = 0; i < 4; i++) if (firstbe[i]) hi = 3'(i);
    for (int i = 3; i >= 0; i--) if (firstbe[i]) lo = 3'(i);
    if (firstbe == 4'h0) return 12'd1;
    return {9'd0, 3'(hi - lo + 3'd1)};
  endfunction

  // Low two address bits of a completion: index of the lowest enabled byte.
  function automatic logic [1:0] cpl_lo2(input logic [3:0] firstbe);
    logic [1:0] lo;
    lo = 2'd0;
    for (int i = 3; i >= 0; i--) if (firstbe[i]) lo = 2'(i);
    return lo;
  endfunction

endpackage

// File: rtl/pcie_mmio_responder_if.sv
// RX/TX TLP streams plus the simple register bus seen by the MMIO completer.
interface pcie_mmio_responder_if #(
  parameter int ADDR_W = 12
);
  logic [63:0]       rx_tdata;
  logic [7:0]        rx_tkeep;
  logic              rx_tlast;
  logic              rx_tvalid;
  logic              rx_tready;
  logic [63:0]       tx_tdata;
  logic [7:0]        tx_tkeep;
  logic              tx_tlast;
  logic              tx_tvalid;
  logic              tx_tready;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr;
  logic [31:0]       reg_wdata;
  logic [3:0]        reg_wbe;
  logic              reg_rd;
  logic [31:0]       reg_rdata;
  logic              reg_rvalid;

  // Completer view.
  modport slave (
    input  rx_tdata, rx_tkeep, rx_tlast, rx_tvalid,
    output rx_tready,
    output tx_tdata, tx_tkeep, tx_tlast, tx_tvalid,
    input  tx_tready,
    output reg_addr, reg_wr, reg_wdata, reg_wbe, reg_rd,
    input  reg_rdata, reg_rvalid
  );

  // PCIe core / register file view.
  modport master (
    output rx_tdata, rx_tkeep, rx_tlast, rx_tvalid,
    input  rx_tready,
    input  tx_tdata, tx_tkeep, tx_tlast, tx_tvalid,
    output tx_tready,
    input  reg_addr, reg_wr, reg_wdata, reg_wbe, reg_rd,
    output reg_rdata, reg_rvalid
  );
endinterface

// File: rtl/pcie_mmio_responder.sv
// MMIO completer: decodes 1-DW 3DW memory reads/writes from the RX stream,
// drives the register bus and returns a two-beat CplD for reads. Anything
// else is swallowed up to tlast. Only one request is ever in flight.
module pcie_mmio_responder
  import pcie_mmio_responder_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           completer_id,
  pcie_mmio_responder_if.slave  bus
);

  localparam int TMR_W = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(RD_TIMEOUT);

  rsp_state_e       state_reg;
  tlp_3dw_header    req_reg;
  logic [31:0]      rdata_reg;
  logic [TMR_W-1:0] timer_reg;

  tlp_dw0_t      rx_dw0;
  req_dw1_t      rx_dw1;
  addr_dw2_t     rx_dw2;
  logic          rx_fire;
  logic          supported;
  tlp_cpl_header cpl_hdr;
  logic [63:0]   cpl_beat0;
  logic [63:0]   cpl_beat1;

  assign rx_dw0  = tlp_dw0_t'(bus.rx_tdata[31:0]);
  assign rx_dw1  = req_dw1_t'(bus.rx_tdata[63:32]);
  assign rx_dw2  = addr_dw2_t'(bus.rx_tdata[31:0]);
  assign rx_fire = bus.rx_tvalid && bus.rx_tready;

  assign bus.tx_tkeep = 8'hFF;

  // First-beat filter: only 1-DW, unpoisoned, 3DW memory reads/writes proceed.
  always_comb begin
    supported = ((rx_dw0.fmt == MRd_3DW_NO_DATA) || (rx_dw0.fmt == MWr_3DW_DATA))
                && (rx_dw0.typ == MEMORY_RW)
                && (rx_dw0.length == 10'd1)
                && !rx_dw0.poison;
  end

  // Completion header assembled from the latched request.
  always_comb begin
    cpl_hdr                    = '0;
    cpl_hdr.f.dw0.fmt          = CPLD_FMT;
    cpl_hdr.f.dw0.typ          = CPLD_TYPE;
    cpl_hdr.f.dw0.tc           = req_reg.f.dw0.tc;
    cpl_hdr.f.dw0.attr         = req_reg.f.dw0.attr;
    cpl_hdr.f.dw0.length       = 10'd1;
    cpl_hdr.f.dw1.cplid        = completer_id;
    cpl_hdr.f.dw1.bytecount    = cpl_bytecount(req_reg.f.dw1.firstbe);
    cpl_hdr.f.dw2.reqid        = req_reg.f.dw1.reqid;
    cpl_hdr.f.dw2.tag          = req_reg.f.dw1.tag;
    cpl_hdr.f.dw2.loweraddr    = {req_reg.f.dw2.addr[4:0], cpl_lo2(req_reg.f.dw1.firstbe)};
    cpl_beat0                  = {cpl_hdr.f.dw1, cpl_hdr.f.dw0};
    cpl_beat1                  = {rdata_reg, cpl_hdr.f.dw2};
  end

  // Request/completion FSM; every bus output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      req_reg       <= '0;
      rdata_reg     <= '0;
      timer_reg     <= '0;
      bus.rx_tready <= 1'b0;
      bus.tx_tdata  <= '0;
      bus.tx_tlast  <= 1'b0;
      bus.tx_tvalid <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wr    <= 1'b0;
      bus.reg_wdata <= '0;
      bus.reg_wbe   <= '0;
      bus.reg_rd    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          bus.rx_tready <= 1'b1;
          if (rx_fire) begin
            req_reg.f.dw0 <= rx_dw0;
            req_reg.f.dw1 <= rx_dw1;
            // A single-beat TLP is a runt; stay here and treat the next beat as a header.
            if (!bus.rx_tlast) state_reg <= supported ? ST_HDR2 : ST_DROP;
          end
        end
        ST_HDR2: begin
          if (rx_fire) begin
            req_reg.f.dw2 <= rx_dw2;
            if (bus.rx_tlast) begin
              bus.rx_tready <= 1'b0;
              bus.reg_addr  <= {rx_dw2.addr[ADDR_W-3:0], 2'b00};
              if (req_reg.f.dw0.fmt == MWr_3DW_DATA) begin
                bus.reg_wr    <= 1'b1;
                bus.reg_wdata <= bus.rx_tdata[63:32];
                bus.reg_wbe   <= req_reg.f.dw1.firstbe;
                state_reg     <= ST_WRITE;
              end else begin
                bus.reg_rd <= 1'b1;
                state_reg  <= ST_READ;
              end
            end else begin
              // Longer than the header says: discard, never write.
              state_reg <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (rx_fire && bus.rx_tlast) state_reg <= ST_IDLE;
        end
        ST_WRITE: begin
          bus.reg_wr    <= 1'b0;
          bus.rx_tready <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        ST_READ: begin
          bus.reg_rd <= 1'b0;
          timer_reg  <= '0;
          state_reg  <= ST_RWAIT;
        end
        ST_RWAIT: begin
          // Real data beats a timeout arriving in the same cycle.
          if (bus.reg_rvalid || (timer_reg >= TMR_LIMIT)) begin
            rdata_reg     <= bus.reg_rvalid ? bus.reg_rdata : 32'hFFFF_FFFF;
            bus.tx_tdata  <= cpl_beat0;
            bus.tx_tlast  <= 1'b0;
            bus.tx_tvalid <= 1'b1;
            state_reg     <= ST_CPL0;
          end else if (timer_reg != '1) begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_CPL0: begin
          if (bus.tx_tready) begin
            bus.tx_tdata <= cpl_beat1;
            bus.tx_tlast <= 1'b1;
            state_reg    <= ST_CPL1;
          end
        end
        ST_CPL1: begin
          if (bus.tx_tready) begin
            bus.tx_tdata  <= '0;
            bus.tx_tlast  <= 1'b0;
            bus.tx_tvalid <= 1'b0;
            bus.rx_tready <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pcie_mmio_responder.md
# pcie_mmio_responder

Completer-side MMIO target for the PCIe user interface. Consumes the 64-bit RX TLP stream from the hard PCIe core, decodes 1-DW 3DW-header memory reads and writes addressed to BAR0, drives a simple 32-bit register bus, and returns CplD TLPs on the 64-bit TX stream. Sits between the PCIe core's RX/TX AXI-stream ports and the board register file.

## Interface
Parameters:
- ADDR_W, 12, register-bus byte-address width; `reg_addr = {tlp_addr[ADDR_W-1:2], 2'b00}`
- RD_TIMEOUT, 255, cycles to wait for `reg_rvalid` before completing with 32'hFFFF_FFFF

Ports:
- Reset is asynchronous and active-high. There is one clock.
- clk  in  1  sole clock, PCIe user clock
- rst  in  1  asynchronous, active-high reset
- completer_id  in  16  bus/dev/func, placed in the CplD cplid field
- rx_tdata  in  64  beat n: DW(2n) in [31:0], DW(2n+1) in [63:32]
- rx_tkeep  in  8  byte enables; only [7:4] varies on the last beat
- rx_tlast  in  1  last beat of TLP
- rx_tvalid  in  1  RX beat valid
- rx_tready  out  1  RX beat accept
- tx_tdata  out  64  CplD beats, same DW packing as RX
- tx_tkeep  out  8  always 8'hFF
- tx_tlast  out  1  asserted on CplD beat 1
- tx_tvalid  out  1  TX beat valid
- tx_tready  in  1  TX beat accept
- reg_addr  out  ADDR_W  register byte address, DW aligned
- reg_wr  out  1  one-cycle write strobe
- reg_wdata  out  32  write data, byte 0 in [7:0]
- reg_wbe  out  4  = TLP firstbe
- reg_rd  out  1  one-cycle read strobe
- reg_rdata  in  32  read data
- reg_rvalid  in  1  read data valid; earliest one cycle after `reg_rd`

## Operation
- Header fields use the shared TLP header union layout. Each header DW is big-endian-bit as defined in the package, so DW0[31] is r0.
- The block accepts MRd_3DW_NO_DATA and MWr_3DW_DATA with type MEMORY_RW, length 1 and poison 0.
- Every other TLP is consumed and dropped until `tlast`. This includes 4DW headers, length != 1, Cfg, Cpl and poisoned TLPs. No UR completion is generated.
- States:
  - IDLE: latch DW0/DW1 on the accepted beat. Go to HDR2, or to DROP if the TLP is unsupported, or stay in IDLE if `tlast` (runt TLP).
  - HDR2: latch addr (DW2) and, for MWr, data (DW3). On `tlast`, go to WRITE or READ. If `tlast` is not set, go to DROP; a write is not performed.
  - DROP: accept beats until `tlast`, then go to IDLE.
  - WRITE: `reg_wr` for 1 cycle, then IDLE.
  - READ: `reg_rd` for 1 cycle, then RWAIT.
  - RWAIT: capture `reg_rdata` on `reg_rvalid`, or 32'hFFFF_FFFF when the timeout counter reaches RD_TIMEOUT. Then CPL0.
  - CPL0: present CplD beat 0; advance on `tx_tready`.
  - CPL1: present beat 1 with `tlast`; advance on `tx_tready` to IDLE.
- `rx_tready` = 1 only in IDLE, HDR2 and DROP.
- CplD contents:
  - DW0: format=MWr_3DW_DATA (with data), type=Cpl, tc and attr copied from the request, digest 0, poison 0, length 1.
  - DW1: cplid=completer_id, status 0, bcm 0, bytecount.
  - DW2: reqid and tag copied, r 0, loweraddr = {addr[4:0], lo2}.
  - DW3: data.
- bytecount and lo2 follow the PCIe 1-DW rule from firstbe:
  - 4'h0 → 1, lo2 0.
  - Otherwise bytecount = (index of highest set bit) − (index of lowest set bit) + 1, and lo2 = index of lowest set bit.
- MWr with firstbe 4'h0 still pulses `reg_wr` with `reg_wbe`=0.

## Timing
- Reset values: `rx_tready` 0, `tx_tvalid` 0, `tx_tlast` 0, `tx_tdata` 0, `tx_tkeep` 8'hFF, `reg_wr` 0, `reg_rd` 0, `reg_addr` 0, `reg_wdata` 0, `reg_wbe` 0.
- State is IDLE after reset. `rx_tready` rises on the first clock after `rst` deasserts.
- Write latency: `reg_wr` is asserted in the cycle after the HDR2 `tlast` beat is accepted.
- Read latency: `reg_rd` is asserted in the cycle after HDR2. `tx_tvalid` rises in the cycle after `reg_rvalid`.
- `tx_tvalid` and `tx_tdata` are held stable until `tx_tready`. A stalled TX back-pressures RX, so there is only ever one request in flight.
- Timeout counter:
  - 8-bit minimum, cleared on entering RWAIT, saturating.
  - A `reg_rvalid` in the same cycle as the timeout wins, and the real data is returned.
- Reset asserted mid-TLP or mid-completion forces IDLE asynchronously and drops the partial packet. The first beat after reset is treated as a header.

## Structure
- Add the following to the shared TLP package:
  - A state enum.
  - A constant for the CplD format/type.
  - Pure functions `cpl_bytecount(firstbe)` and `cpl_lo2(firstbe)`.
- The responder builds DWs with the existing `tlp_3dw_header` and `tlp_cpl_header` unions; it does not use raw bit slicing.
- Single module, no sub-module. The register bus is left for the board-level register file.

## Test plan
- MWr: addr 32'h0000_0010, firstbe F, data 32'hDEADBEEF → one `reg_wr` cycle with `reg_addr`=12'h010, `reg_wdata`=DEADBEEF, `reg_wbe`=F, and no TX activity.
- MRd: reqid 16'h0100, tag 8'h2A, addr 32'h0000_0024, firstbe F; `reg_rvalid` arrives 3 cycles later with 32'h12345678 → CplD with length 1, bytecount 4, loweraddr 7'h24, tag 2A, data 12345678, `tlast` on beat 1.
- MRd with firstbe 4'b0110 → bytecount 2, loweraddr low bits 2'b01. MRd with firstbe 0 → bytecount 1.
- MRd with `reg_rvalid` never returned → CplD data FFFF_FFFF after RD_TIMEOUT+1 cycles. `tx_tready` held low 5 cycles → `tx_tvalid`/`tx_tdata` stable throughout and `rx_tready` stays 0.
- MWr with length 2, then a 4DW MRd, then a Cfg0 TLP → all are consumed until `tlast`, with no `reg_wr`, no `reg_rd` and no TX.
- `rst` pulsed between HDR2 and WRITE → no `reg_wr`; the next valid MRd completes normally.
